// File: rtl/vocab_search_engine.sv
// vocab_search_engine: scans a vocabulary region of zero-terminated entries for one word
// Ports: clk, rst_n (async, active-low); start/abort handshake; prefix_mode, word,
// start_addr, end_addr sampled at start; mem_re/mem_addr/mem_rdata read port with
// one-cycle latency; busy/done status; found, match_index, match_addr results.
module vocab_search_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int WORD_LENGTH = 4,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              prefix_mode,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
  input  logic [ADDR_WIDTH-1:0]             start_addr,
  input  logic [ADDR_WIDTH-1:0]             end_addr,
  output logic                              mem_re,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              busy,
  output logic                              done,
  output logic                              found,
  output logic [INDEX_WIDTH-1:0]            match_index,
  output logic [ADDR_WIDTH-1:0]             match_addr
);
  localparam int PW = $clog2(WORD_LENGTH + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, COMPARE, SKIP_ISSUE, SKIP_COMPARE, DONE} state_t;
  state_t                            state_q, state_d;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q, word_d;
  logic                              prefix_q, prefix_d;
  logic [PW-1:0]                     n_q, n_d, p_q, p_d, start_n;
  logic [ADDR_WIDTH-1:0]             end_q, end_d, addr_q, addr_d, entry_q, entry_d, next_addr;
  logic [INDEX_WIDTH-1:0]            index_q, index_d, match_index_q, match_index_d;
  logic [ADDR_WIDTH-1:0]             match_addr_q, match_addr_d;
  logic                              found_q, found_d;
  logic [DATA_WIDTH-1:0]             cur_char;
  logic                              hit, is_zero, match, adv, last;
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    prefix_d      = prefix_q;
    n_d           = n_q;
    p_d           = p_q;
    end_d         = end_q;
    addr_d        = addr_q;
    entry_d       = entry_q;
    index_d       = index_q;
    found_d       = found_q;
    match_index_d = match_index_q;
    match_addr_d  = match_addr_q;
    mem_re        = 1'b0;
    start_n       = PW'(WORD_LENGTH);
    for (int i = WORD_LENGTH - 1; i >= 0; i--)
      if (word[i*DATA_WIDTH +: DATA_WIDTH] == '0) start_n = PW'(i);
    cur_char = '0;
    for (int i = 0; i < WORD_LENGTH; i++)
      if (p_q == PW'(i)) cur_char = word_q[i*DATA_WIDTH +: DATA_WIDTH];
    next_addr = addr_q + ADDR_WIDTH'(1);
    hit       = mem_rdata == cur_char;
    is_zero   = mem_rdata == '0;
    match     = prefix_q ? (hit && p_q == n_q - PW'(1)) : (p_q == n_q && is_zero);
    adv       = hit && p_q < n_q;
    // look ahead at the region end so the final read goes straight to DONE
    last      = next_addr == end_q;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        word_d        = word;
        prefix_d      = prefix_mode;
        n_d           = start_n;
        end_d         = end_addr;
        addr_d        = start_addr;
        entry_d       = start_addr;
        p_d           = '0;
        index_d       = '0;
        found_d       = 1'b0;
        match_index_d = '0;
        match_addr_d  = '0;
        state_d       = ISSUE;
      end
      ISSUE: if (addr_q == end_q || n_q == '0) state_d = DONE;
        else begin
          mem_re  = 1'b1;
          state_d = COMPARE;
        end
      SKIP_ISSUE: if (addr_q == end_q) state_d = DONE;
        else begin
          mem_re  = 1'b1;
          state_d = SKIP_COMPARE;
        end
      COMPARE: begin
        addr_d = next_addr;
        if (match) begin
          found_d       = 1'b1;
          match_index_d = index_q;
          match_addr_d  = entry_q;
          state_d       = DONE;
        end else if (adv) begin
          p_d     = (p_q == PW'(WORD_LENGTH)) ? p_q : p_q + PW'(1);
          state_d = last ? DONE : ISSUE;
        end else if (is_zero) begin
          entry_d = next_addr;
          index_d = index_q + INDEX_WIDTH'(1);
          p_d     = '0;
          state_d = last ? DONE : ISSUE;
        end else state_d = last ? DONE : SKIP_ISSUE;
      end
      SKIP_COMPARE: begin
        addr_d = next_addr;
        if (is_zero) begin
          entry_d = next_addr;
          index_d = index_q + INDEX_WIDTH'(1);
          p_d     = '0;
          state_d = last ? DONE : ISSUE;
        end else state_d = last ? DONE : SKIP_ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      word_q        <= '0;
      prefix_q      <= 1'b0;
      n_q           <= '0;
      p_q           <= '0;
      end_q         <= '0;
      addr_q        <= '0;
      entry_q       <= '0;
      index_q       <= '0;
      found_q       <= 1'b0;
      match_index_q <= '0;
      match_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      prefix_q      <= prefix_d;
      n_q           <= n_d;
      p_q           <= p_d;
      end_q         <= end_d;
      addr_q        <= addr_d;
      entry_q       <= entry_d;
      index_q       <= index_d;
      found_q       <= found_d;
      match_index_q <= match_index_d;
      match_addr_q  <= match_addr_d;
    end
  end
  assign mem_addr    = mem_re ? addr_q : '0;
  assign busy        = state_q != IDLE && state_q != DONE;
  assign done        = state_q == DONE;
  assign found       = found_q;
  assign match_index = match_index_q;
  assign match_addr  = match_addr_q;
endmodule

// File: tb/tb_vocab_search_engine.sv
// tb_vocab_search_engine: table-driven scoreboard bench for vocab_search_engine
module tb_vocab_search_engine;
  localparam logic [7:0] Z = 8'h00;
  typedef struct {
    logic [31:0] word;
    logic        pm;
    logic [7:0]  sa;
    logic [7:0]  ea;
    logic        f;
    logic [7:0]  idx;
    logic [7:0]  addr;
    int          reads;
  } vec_t;
  typedef struct {
    logic       f;
    logic [7:0] idx;
    logic [7:0] addr;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, prefix_mode = 1'b0, start4 = 1'b0;
  logic [31:0] word = '0;
  logic [7:0]  start_addr = '0, end_addr = '0;
  logic [7:0]  mem_rdata = '0, mem_addr, match_index, match_addr;
  logic        mem_re, busy, done, found;
  logic [3:0]  sa4 = '0, ea4 = '0, mem_addr4, match_addr4;
  logic [7:0]  mem_rdata4 = '0, match_index4;
  logic        mem_re4, busy4, done4, found4;
  logic [7:0]  vmem [256];
  logic [7:0]  vmem4 [16];
  int          checks = 0, errors = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vt[12];

  vocab_search_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .prefix_mode(prefix_mode),
    .word(word), .start_addr(start_addr), .end_addr(end_addr), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .done(done), .found(found),
    .match_index(match_index), .match_addr(match_addr));

  vocab_search_engine #(.ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort), .prefix_mode(prefix_mode),
    .word(word), .start_addr(sa4), .end_addr(ea4), .mem_re(mem_re4),
    .mem_addr(mem_addr4), .mem_rdata(mem_rdata4), .busy(busy4), .done(done4), .found(found4),
    .match_index(match_index4), .match_addr(match_addr4));

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_re) mem_rdata <= vmem[mem_addr];
  always @(posedge clk) if (mem_re4) mem_rdata4 <= vmem4[mem_addr4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] w4(input logic [7:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  always @(negedge clk) if (done) begin
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done got 1 expected 0");
    end else begin
      mon_e = sb.pop_front();
      chk("found", found, mon_e.f);
      chk("match_index", match_index, mon_e.idx);
      chk("match_addr", match_addr, mon_e.addr);
    end
  end

  task automatic run(input vec_t v, input bit poke);
    int e, reads;
    @(negedge clk);
    word = v.word; prefix_mode = v.pm; start_addr = v.sa; end_addr = v.ea; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_acc", busy, 1);
    chk("found_clr", found, 0);
    sb.push_back('{v.f, v.idx, v.addr});
    reads = mem_re ? 1 : 0;
    e = 0;
    while (!done && e < 100) begin
      if (poke && e == 3) begin
        word = w4("a", "b", Z, Z); prefix_mode = 1'b1; start = 1'b1;
      end
      @(posedge clk); #1 start = 1'b0;
      e++;
      if (!done && mem_re) reads++;
    end
    chk("done_edge", e, (v.reads == 0) ? 1 : 2 * v.reads);
    chk("reads", reads, v.reads);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    chk("persist_found", found, v.f);
  endtask

  task automatic begin_search(input vec_t v);
    @(negedge clk);
    word = v.word; prefix_mode = v.pm; start_addr = v.sa; end_addr = v.ea; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wrap_test();
    logic [3:0] aq[$];
    logic [3:0] ea[3];
    int e;
    ea[0] = 4'd14; ea[1] = 4'd15; ea[2] = 4'd0;
    @(negedge clk);
    word = w4("x", "y", Z, Z); prefix_mode = 1'b0; sa4 = 4'd14; ea4 = 4'd2; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    if (mem_re4) aq.push_back(mem_addr4);
    e = 0;
    while (!done4 && e < 100) begin
      @(posedge clk); #1 e++;
      if (mem_re4) aq.push_back(mem_addr4);
    end
    chk("wrap_done_edge", e, 6);
    chk("wrap_reads", aq.size(), 3);
    for (int i = 0; i < 3 && i < aq.size(); i++) chk("wrap_addr_seq", aq[i], ea[i]);
    chk("wrap_found", found4, 1);
    chk("wrap_match_addr", match_addr4, 14);
    chk("wrap_match_index", match_index4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) vmem[i] = "z";
    for (int i = 0; i < 16; i++) vmem4[i] = "q";
    vmem[0] = "a"; vmem[1] = "b"; vmem[2] = Z;
    vmem[3] = "c"; vmem[4] = "d"; vmem[5] = Z;
    vmem[6] = "c"; vmem[7] = "a"; vmem[8] = "t"; vmem[9] = Z;
    vmem4[14] = "x"; vmem4[15] = "y"; vmem4[0] = Z;
    vt[0]  = '{w4("c", "d", Z, Z),   1'b0, 8'd0, 8'd6,  1'b1, 8'd1, 8'd3, 6};
    vt[1]  = '{w4("c", Z, Z, Z),     1'b0, 8'd0, 8'd6,  1'b0, 8'd0, 8'd0, 6};
    vt[2]  = '{w4("c", Z, Z, Z),     1'b1, 8'd0, 8'd6,  1'b1, 8'd1, 8'd3, 4};
    vt[3]  = '{w4(Z, "c", Z, Z),     1'b0, 8'd0, 8'd6,  1'b0, 8'd0, 8'd0, 0};
    vt[4]  = '{w4("c", "d", Z, Z),   1'b0, 8'd4, 8'd4,  1'b0, 8'd0, 8'd0, 0};
    vt[5]  = '{w4("c", "a", "t", Z), 1'b0, 8'd0, 8'd10, 1'b1, 8'd2, 8'd6, 10};
    vt[6]  = '{w4("c", "a", Z, Z),   1'b1, 8'd0, 8'd10, 1'b1, 8'd2, 8'd6, 8};
    vt[7]  = '{w4("c", "a", Z, Z),   1'b0, 8'd0, 8'd10, 1'b0, 8'd0, 8'd0, 10};
    vt[8]  = '{w4("c", "a", "t", Z), 1'b1, 8'd6, 8'd9,  1'b1, 8'd0, 8'd6, 3};
    vt[9]  = '{w4("c", "a", "t", Z), 1'b0, 8'd6, 8'd9,  1'b0, 8'd0, 8'd0, 3};
    vt[10] = '{w4("c", "d", Z, Z),   1'b0, 8'd3, 8'd6,  1'b1, 8'd0, 8'd3, 3};
    vt[11] = '{w4("a", "b", "c", "d"), 1'b0, 8'd0, 8'd3, 1'b0, 8'd0, 8'd0, 3};
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_match_index", match_index, 0);
    chk("rst_match_addr", match_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) run(vt[i], 1'b0);
    run(vt[0], 1'b1);
    begin_search(vt[5]);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_found", found, 0);
    chk("abort_mem_re", mem_re, 0);
    repeat (30) @(posedge clk);
    run(vt[0], 1'b0);
    begin_search(vt[5]);
    repeat (4) @(posedge clk);
    #1 chk("mid_mem_re", mem_re, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_re", mem_re, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_done", done, 0);
    chk("midrst_found", found, 0);
    @(negedge clk) rst_n = 1'b1;
    run(vt[5], 1'b0);
    wrap_test();
    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
